// File: rtl/bme280_sweep_scheduler.sv
// bme280_sweep_scheduler
// Walks register_selector from FIRST_SEL to LAST_SEL. For each register it
// issues one en pulse to the I2C/BME280 wrapper and waits for ctrl_done or
// a timeout. The returned byte (or 8'hFF on timeout) goes into a 16-entry
// shadow buffer that the host can read at any time. A sweep starts on a
// host start pulse or on a periodic request.
//
// Ports:
//   clk, rst                 system clock, async active-low reset
//   start, auto_en           one-shot sweep request / periodic sweep enable
//   en, register_selector    transaction request and register index to wrapper
//   ctrl_done, ctrl_data     completion pulse and read byte from wrapper
//   busy, frame_valid        not-idle flag / one-cycle end-of-sweep pulse
//   timeout_err              sticky timeout flag for the current/last sweep
//   sweep_count              completed sweeps, wraps modulo 256
//   rd_addr, rd_data         host buffer read port, one-cycle latency
//
// state | meaning
// IDLE  | waiting for start or a pending periodic request
// ISSUE | en asserted for the current register
// WAIT  | waiting for ctrl_done or timeout expiry
// GAP   | idle spacing before the next en pulse
// DONE  | frame_valid asserted, sweep counted
module bme280_sweep_scheduler #(
  parameter int unsigned FIRST_SEL      = 0,
  parameter int unsigned LAST_SEL       = 15,
  parameter int unsigned PERIOD_CYCLES  = 50000000,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned GAP_CYCLES     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       auto_en,
  output logic       en,
  output logic [3:0] register_selector,
  input  logic       ctrl_done,
  input  logic [7:0] ctrl_data,
  output logic       busy,
  output logic       frame_valid,
  output logic       timeout_err,
  output logic [7:0] sweep_count,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam logic [3:0] FIRST = FIRST_SEL[3:0];
  localparam logic [3:0] LAST  = LAST_SEL[3:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [31:0] period_q, period_d;
  logic        pending_q, pending_d;
  logic [3:0]  sel_q, sel_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic        frame_valid_q, frame_valid_d;
  logic        timeout_err_q, timeout_err_d;
  logic [7:0]  sweep_count_q, sweep_count_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic [7:0]  buf_q [16];
  logic [7:0]  buf_d [16];

  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    sel_d         = sel_q;
    en_d          = 1'b0;
    frame_valid_d = 1'b0;
    timeout_err_d = timeout_err_q;
    sweep_count_d = sweep_count_q;
    pending_d     = pending_q;
    period_d      = period_q;
    buf_d         = buf_q;
    // Read uses the pre-write buffer contents, so a same-cycle write
    // returns the old value.
    rd_data_d     = buf_q[rd_addr];

    case (state_q)
      S_IDLE: begin
        if (start || pending_q) begin
          sel_d         = FIRST;
          timeout_err_d = 1'b0;
          pending_d     = 1'b0;
          en_d          = 1'b1;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // ctrl_done takes priority over a coincident timeout expiry.
        if (ctrl_done) begin
          buf_d[sel_q] = ctrl_data;
          tmr_d        = '0;
          state_d      = S_GAP;
        end else if (tmr_q == TIMEOUT_CYCLES - 1) begin
          buf_d[sel_q]  = 8'hFF;
          timeout_err_d = 1'b1;
          tmr_d         = '0;
          state_d       = S_GAP;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      S_GAP: begin
        if (tmr_q == GAP_CYCLES - 1) begin
          tmr_d = '0;
          if (sel_q == LAST) begin
            frame_valid_d = 1'b1;
            sweep_count_d = sweep_count_q + 8'd1;
            state_d       = S_DONE;
          end else begin
            sel_d   = sel_q + 4'd1;
            en_d    = 1'b1;
            state_d = S_ISSUE;
          end
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A wrap in the same cycle that a request is consumed re-arms pending.
    if (!auto_en) begin
      period_d  = '0;
      pending_d = 1'b0;
    end else if (period_q == PERIOD_CYCLES - 1) begin
      period_d  = '0;
      pending_d = 1'b1;
    end else begin
      period_d = period_q + 32'd1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      tmr_q         <= '0;
      period_q      <= '0;
      pending_q     <= 1'b0;
      sel_q         <= FIRST;
      en_q          <= 1'b0;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      sweep_count_q <= '0;
      rd_data_q     <= '0;
      buf_q         <= '{default: 8'h00};
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      period_q      <= period_d;
      pending_q     <= pending_d;
      sel_q         <= sel_d;
      en_q          <= en_d;
      busy_q        <= busy_d;
      frame_valid_q <= frame_valid_d;
      timeout_err_q <= timeout_err_d;
      sweep_count_q <= sweep_count_d;
      rd_data_q     <= rd_data_d;
      buf_q         <= buf_d;
    end
  end

  assign en                = en_q;
  assign register_selector = sel_q;
  assign busy              = busy_q;
  assign frame_valid       = frame_valid_q;
  assign timeout_err       = timeout_err_q;
  assign sweep_count       = sweep_count_q;
  assign rd_data           = rd_data_q;

endmodule

// File: tb/tb_bme280_sweep_scheduler.sv
module tb_bme280_sweep_scheduler;

  localparam int FIRST  = 0;
  localparam int LAST   = 3;
  localparam int PERIOD = 1000;
  localparam int TO     = 100;
  localparam int GAP    = 4;
  localparam int NREG   = LAST - FIRST + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       auto_en;
  logic       en;
  logic [3:0] register_selector;
  logic       ctrl_done;
  logic [7:0] ctrl_data;
  logic       busy;
  logic       frame_valid;
  logic       timeout_err;
  logic [7:0] sweep_count;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  bme280_sweep_scheduler #(
    .FIRST_SEL(FIRST), .LAST_SEL(LAST), .PERIOD_CYCLES(PERIOD),
    .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .en(en),
    .register_selector(register_selector), .ctrl_done(ctrl_done),
    .ctrl_data(ctrl_data), .busy(busy), .frame_valid(frame_valid),
    .timeout_err(timeout_err), .sweep_count(sweep_count),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  // Reference model: expected buffer, sweep bookkeeping, transaction timing.
  logic [7:0] exp_buf [16];
  logic [7:0] exp_cnt   = 8'd0;
  bit         exp_to    = 1'b0;
  bit         in_sweep  = 1'b0;
  bit         busy_chk  = 1'b0;
  int         en_cnt    = 0;
  int         last_en_cyc = 0;
  int         last_eff  = 0;
  int         exp_next  = 0;
  int         starts[$];
  int         frames[$];

  // Responder configuration.
  int         lat_min = 20, lat_max = 20, to_pct = 0;
  int         drop_sel = -1, exact_sel = -1, exact_lat = 0;
  logic [7:0] exact_data = 8'h00;
  bit         data_rand = 1'b0;

  int         r_sel, r_lat;
  logic [7:0] r_dat;

  // Wrapper responder: answers each en after r_lat cycles; a latency beyond
  // the timeout is answered late (must be ignored by the scheduler).
  initial begin
    ctrl_done = 1'b0;
    ctrl_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (en && rst) begin
        r_sel = int'(register_selector);
        if (!in_sweep) begin
          check_eq("sel_first", r_sel, FIRST);
          check_eq("to_clear", timeout_err, 0);
          exp_to = 1'b0;
          en_cnt = 0;
          starts.push_back(cyc);
        end else begin
          check_eq("sel_next", r_sel, exp_next);
          check_eq("en_spacing", cyc - last_en_cyc, last_eff + GAP + 1);
        end
        in_sweep    = 1'b1;
        en_cnt++;
        last_en_cyc = cyc;
        exp_next    = r_sel + 1;
        if (r_sel == drop_sel) r_lat = TO + 1;
        else if (r_sel == exact_sel) r_lat = exact_lat;
        else if (int'($urandom_range(99, 0)) < to_pct) r_lat = TO + 1;
        else r_lat = int'($urandom_range(lat_max, lat_min));
        if (r_sel == exact_sel) r_dat = exact_data;
        else if (data_rand) r_dat = 8'($urandom);
        else r_dat = 8'hA0 + 8'(r_sel);
        if (r_lat <= TO) begin
          exp_buf[r_sel] = r_dat;
          last_eff = r_lat;
        end else begin
          exp_buf[r_sel] = 8'hFF;
          exp_to = 1'b1;
          last_eff = TO;
        end
        repeat (r_lat) @(posedge clk);
        #1 ctrl_done = 1'b1; ctrl_data = r_dat;
        @(posedge clk);
        #1 ctrl_done = 1'b0; ctrl_data = 8'($urandom);
      end
    end
  end

  // End-of-sweep monitor.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (busy_chk) begin
        check_eq("busy_after_frame", busy, 0);
        busy_chk = 1'b0;
      end
      if (frame_valid) begin
        frames.push_back(cyc);
        exp_cnt = exp_cnt + 8'd1;
        check_eq("sweep_count", sweep_count, exp_cnt);
        check_eq("timeout_err", timeout_err, exp_to);
        check_eq("en_count", en_cnt, NREG);
        check_eq("frame_spacing", cyc - last_en_cyc, last_eff + GAP + 1);
        in_sweep = 1'b0;
        busy_chk = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      step();
      check_eq($sformatf("buf%0d", a), rd_data, exp_buf[a]);
    end
  endtask

  task automatic wait_frame();
    int k = 0;
    while (!frame_valid && k < 3000) begin
      step();
      k++;
    end
    check_eq("frame_seen", frame_valid, 1);
    step();
  endtask

  task automatic do_sweep();
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("en_after_start", en, 1);
    wait_frame();
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (starts.size() < n && k < budget) begin
      step();
      k++;
    end
    check_eq("starts_reached", starts.size() >= n, 1);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames.size() < n && k < budget) begin
      step();
      k++;
    end
    check_eq("frames_reached", frames.size() >= n, 1);
  endtask

  initial begin
    int c0, nf, k;
    for (int i = 0; i < 16; i++) exp_buf[i] = 8'h00;
    rst = 1'b0; start = 1'b0; auto_en = 1'b0; rd_addr = 4'd0;

    // Reset state
    repeat (3) step();
    check_eq("rst_en", en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_fv", frame_valid, 0);
    check_eq("rst_to", timeout_err, 0);
    check_eq("rst_cnt", sweep_count, 0);
    check_eq("rst_sel", register_selector, FIRST);
    check_eq("rst_rd", rd_data, 0);
    rst = 1'b1;
    step();
    read_all();

    // Single sweep, fixed latency 20, data A0+sel
    do_sweep();
    read_all();
    check_eq("sel_hold", register_selector, LAST);

    // Timeout on sel 2, then flag cleared by the next sweep
    drop_sel = 2;
    do_sweep();
    check_eq("to_after_sweep", timeout_err, 1);
    read_all();
    drop_sel = -1;
    do_sweep();
    check_eq("to_cleared", timeout_err, 0);

    // ctrl_done coincident with timeout expiry
    exact_sel = 1; exact_lat = TO; exact_data = 8'h5A;
    do_sweep();
    read_all();
    exact_sel = -1;

    // Randomized sweeps with occasional timeouts
    data_rand = 1'b1; lat_min = 1; lat_max = 40; to_pct = 15;
    repeat (6) begin
      do_sweep();
      read_all();
    end

    // Periodic sweeps
    to_pct = 0; lat_max = 30;
    starts.delete(); frames.delete();
    c0 = cyc;
    auto_en = 1'b1;
    wait_starts(1, 1200);
    check_eq("first_period", starts[0] - c0, PERIOD + 1);
    repeat (10) step();
    start = 1'b1; step(); start = 1'b0;
    wait_starts(3, 2500);
    check_eq("period_1", starts[1] - starts[0], PERIOD);
    check_eq("period_2", starts[2] - starts[1], PERIOD);

    // Period wrap while a manual sweep is busy
    lat_min = 30; lat_max = 30;
    wait_frames(3, 1000);
    k = 0;
    while (cyc < starts[2] + 900 && k < 1000) begin step(); k++; end
    start = 1'b1; step(); start = 1'b0;
    check_eq("en_manual", en, 1);
    wait_starts(5, 600);
    wait_frames(4, 600);
    check_eq("pending_after_done", starts[4] - frames[3], 2);
    k = 0;
    while (cyc < starts[4] + 300 && k < 1000) begin step(); k++; end
    check_eq("no_extra", starts.size(), 5);
    auto_en = 1'b0;
    wait_frames(5, 600);
    step();
    read_all();

    // sweep_count wrap
    lat_min = 1; lat_max = 3;
    k = 0;
    while (exp_cnt != 8'd255 && k < 300) begin do_sweep(); k++; end
    do_sweep();
    check_eq("cnt_wrap", sweep_count, 0);

    // Reset during WAIT with a late ctrl_done afterwards
    exact_sel = 1; exact_lat = 50; exact_data = 8'h77;
    start = 1'b1; step(); start = 1'b0;
    k = 0;
    while (!(register_selector == 4'd1 && busy && !en) && k < 100) begin step(); k++; end
    repeat (5) step();
    nf = frames.size();
    rst = 1'b0;
    repeat (3) step();
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_sel", register_selector, FIRST);
    for (int i = 0; i < 16; i++) exp_buf[i] = 8'h00;
    exp_cnt = 8'd0; exp_to = 1'b0; in_sweep = 1'b0; busy_chk = 1'b0;
    rst = 1'b1;
    repeat (80) step();
    check_eq("post_rst_frames", frames.size(), nf);
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_cnt", sweep_count, 0);
    check_eq("post_rst_to", timeout_err, 0);
    read_all();
    exact_sel = -1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
